// File: rtl/entry_buffer_pkg.sv
// Shared constants, types and helpers for the keypad entry buffer.
package entry_buffer_pkg;

    localparam int DIGIT_W_DEF = 4;
    localparam int DEPTH_DEF   = 32;

    typedef logic [DIGIT_W_DEF-1:0] digit_t;

    // The keypad decoder reports "no key" as all ones; empty slots reuse that code.
    localparam digit_t BLANK_DIGIT = '1;

    // Bits needed to hold any value in 0..n.
    function automatic int count_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/entry_idle_timer.sv
// Idle counter for the entry buffer: pulses expire after TIMEOUT_CYC idle cycles.
// Only instantiated when ENTRY_AUTOCLR_EN is defined.
module entry_idle_timer
    import entry_buffer_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic clk,
    input  logic rstn,
    input  logic restart,
    input  logic armed,
    output logic expire
);

    localparam int TW = count_width(TIMEOUT_CYC - 1);

    logic [TW-1:0] idle_q;

    assign expire = armed && !restart && (idle_q == TW'(TIMEOUT_CYC - 1));

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            idle_q <= '0;
        end else if (restart || !armed || expire) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_q + TW'(1);
        end
    end

endmodule

// File: rtl/entry_buffer.sv
// Keypad entry buffer: newest digit in slot 0, count/backspace/replace/overflow/accept.
// Optional idle auto-clear is enabled by defining ENTRY_AUTOCLR_EN.
module entry_buffer
    import entry_buffer_pkg::*;
#(
    parameter int DIGIT_W     = DIGIT_W_DEF,
    parameter int DEPTH       = DEPTH_DEF,
    parameter int CNT_W       = count_width(DEPTH),
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     clr,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DIGIT_W-1:0]       digit,
    output logic [DIGIT_W*DEPTH-1:0] data_out,
    output logic [CNT_W-1:0]         count,
    output logic                     empty,
    output logic                     full,
    output logic                     overflow,
    output logic                     accept,
    output logic                     timeout
);

    localparam int                DW    = DIGIT_W * DEPTH;
    localparam logic [DIGIT_W-1:0] BLANK = '1;

    logic [DW-1:0]    data_q, data_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             accept_q, accept_d;
    logic             timeout_q, timeout_d;
    logic             push_ok;
    logic             expire;

    // A blank digit is the keypad's no-key code, so it never counts as a push.
    assign push_ok = push && (digit != BLANK);

`ifdef ENTRY_AUTOCLR_EN
    entry_idle_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_idle_timer (
        .clk     (clk),
        .rstn    (rstn),
        .restart (clr || push || pop),
        .armed   (count_q != '0),
        .expire  (expire)
    );
`else
    // Auto-clear compiled out; a zero timeout is not a usable setting, so this is constant 0.
    assign expire = (TIMEOUT_CYC == 0);
`endif

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        data_d     = data_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        accept_d   = 1'b0;
        timeout_d  = 1'b0;

        if (clr) begin
            data_d     = '1;
            count_d    = '0;
            overflow_d = 1'b0;
        end else if (push_ok && pop && (count_q != '0)) begin
            data_d[DIGIT_W-1:0] = digit;
            accept_d            = 1'b1;
        end else if (push_ok) begin
            if (count_q == CNT_W'(DEPTH)) begin
                overflow_d = 1'b1;
            end else begin
                data_d   = {data_q[DW-DIGIT_W-1:0], digit};
                count_d  = count_q + CNT_W'(1);
                accept_d = 1'b1;
            end
        end else if (pop) begin
            if (count_q != '0) begin
                data_d   = {BLANK, data_q[DW-1:DIGIT_W]};
                count_d  = count_q - CNT_W'(1);
                accept_d = 1'b1;
            end
        end else if (expire) begin
            data_d     = '1;
            count_d    = '0;
            overflow_d = 1'b0;
            timeout_d  = 1'b1;
        end
    end

    // NOTE: the digit slots are reset to BLANK because unused slots must always read blank.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            data_q     <= '1;
            count_q    <= '0;
            overflow_q <= 1'b0;
            accept_q   <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            data_q     <= data_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            accept_q   <= accept_d;
            timeout_q  <= timeout_d;
        end
    end

    assign data_out = data_q;
    assign count    = count_q;
    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_W'(DEPTH));
    assign overflow = overflow_q;
    assign accept   = accept_q;
    assign timeout  = timeout_q;

endmodule

// File: tb/tb_entry_buffer.sv
// Scoreboard bench for entry_buffer (DEPTH=4): a queue-based reference model predicts
// each cycle's outputs and a negedge monitor compares them against the DUT.
module tb_entry_buffer;
    import entry_buffer_pkg::*;

    localparam int DIGIT_W     = 4;
    localparam int DEPTH       = 4;
    localparam int CNT_W       = 3;
    localparam int TIMEOUT_CYC = 8;

    logic                     clk = 1'b0;
    logic                     rstn;
    logic                     clr, push, pop;
    logic [DIGIT_W-1:0]       digit;
    logic [DIGIT_W*DEPTH-1:0] data_out;
    logic [CNT_W-1:0]         count;
    logic                     empty, full, overflow, accept, timeout;

    entry_buffer #(
        .DIGIT_W     (DIGIT_W),
        .DEPTH       (DEPTH),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .clr      (clr),
        .push     (push),
        .pop      (pop),
        .digit    (digit),
        .data_out (data_out),
        .count    (count),
        .empty    (empty),
        .full     (full),
        .overflow (overflow),
        .accept   (accept),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        int          cnt;
        bit          ovf;
        bit          acc;
        bit          tmo;
    } exp_t;

    exp_t   exp_q[$];
    digit_t digs[$];      // digs[0] is the newest digit
    bit     m_ovf;
    int     m_idle;
    int     n_checks = 0;
    int     n_err    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [15:0] packed_view();
        logic [15:0] r;
        r = '1;
        for (int i = 0; i < digs.size(); i++) r[i*DIGIT_W +: DIGIT_W] = digs[i];
        return r;
    endfunction

    function automatic exp_t snapshot(input bit acc, input bit tmo);
        exp_t e;
        e.data = packed_view();
        e.cnt  = digs.size();
        e.ovf  = m_ovf;
        e.acc  = acc;
        e.tmo  = tmo;
        return e;
    endfunction

    task automatic model_reset();
        digs.delete();
        m_ovf  = 1'b0;
        m_idle = 0;
    endtask

    // Applies one cycle of requests to the reference model and queues the prediction.
    task automatic model_step(input bit c, input bit pu, input bit po, input digit_t d);
        bit pe, acc, tmo, fire;
        pe   = pu && (d != BLANK_DIGIT);
        acc  = 1'b0;
        tmo  = 1'b0;
        fire = 1'b0;
`ifdef ENTRY_AUTOCLR_EN
        fire = !c && !pu && !po && (digs.size() > 0) && (m_idle == TIMEOUT_CYC - 1);
        if (c || pu || po || digs.size() == 0 || fire) m_idle = 0;
        else m_idle++;
`endif
        if (c) begin
            digs.delete();
            m_ovf = 1'b0;
        end else if (pe && po && digs.size() > 0) begin
            digs[0] = d;
            acc = 1'b1;
        end else if (pe) begin
            if (digs.size() < DEPTH) begin
                digs.push_front(d);
                acc = 1'b1;
            end else begin
                m_ovf = 1'b1;
            end
        end else if (po) begin
            if (digs.size() > 0) begin
                void'(digs.pop_front());
                acc = 1'b1;
            end
        end else if (fire) begin
            digs.delete();
            m_ovf = 1'b0;
            tmo   = 1'b1;
        end
        exp_q.push_back(snapshot(acc, tmo));
    endtask

    // Driver: inputs change just after a negedge, the model advances on the posedge.
    task automatic step(input bit c, input bit pu, input bit po, input digit_t d);
        clr   = c;
        push  = pu;
        pop   = po;
        digit = d;
        @(posedge clk);
        model_step(c, pu, po, d);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, digit_t'($urandom_range(0, 15)));
    endtask

    // Monitor: every cycle the registered outputs are a response; compare against the queue.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("data_out", 64'(data_out), 64'(e.data));
            check("count",    64'(count),    64'(e.cnt));
            check("empty",    64'(empty),    64'(e.cnt == 0));
            check("full",     64'(full),     64'(e.cnt == DEPTH));
            check("overflow", 64'(overflow), 64'(e.ovf));
            check("accept",   64'(accept),   64'(e.acc));
            check("timeout",  64'(timeout),  64'(e.tmo));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0;
        clr = 1'b0; push = 1'b0; pop = 1'b0; digit = '0;
        model_reset();
        @(negedge clk);
        check("reset data",     64'(data_out), 64'hFFFF);
        check("reset count",    64'(count),    64'd0);
        check("reset empty",    64'(empty),    64'd1);
        check("reset overflow", 64'(overflow), 64'd0);
        check("reset accept",   64'(accept),   64'd0);
        check("reset timeout",  64'(timeout),  64'd0);
        rstn = 1'b1;

        // Push three digits.
        step(0, 1, 0, 4'h1); step(0, 1, 0, 4'h2); step(0, 1, 0, 4'h3);
        check("push3 data",  64'(data_out), 64'hF123);
        check("push3 count", 64'(count),    64'd3);

        // Fill, then overflow.
        step(0, 1, 0, 4'h4);
        check("fill data", 64'(data_out), 64'h1234);
        check("fill full", 64'(full),     64'd1);
        step(0, 1, 0, 4'h5);
        check("ovf data",   64'(data_out), 64'h1234);
        check("ovf flag",   64'(overflow), 64'd1);
        check("ovf accept", 64'(accept),   64'd0);
        step(0, 1, 1, 4'h6);
        check("replace when full keeps ovf", 64'(data_out), 64'h1236);
        step(1, 0, 0, 4'h0);
        check("clr data",     64'(data_out), 64'hFFFF);
        check("clr overflow", 64'(overflow), 64'd0);

        // Backspace.
        step(0, 1, 0, 4'h1); step(0, 1, 0, 4'h2); step(0, 1, 0, 4'h3); step(0, 1, 0, 4'h4);
        step(0, 0, 1, 4'h0); step(0, 0, 1, 4'h0);
        check("pop2 data",  64'(data_out), 64'hFF12);
        check("pop2 count", 64'(count),    64'd2);
        step(0, 0, 1, 4'h0); step(0, 0, 1, 4'h0); step(0, 0, 1, 4'h0);
        check("pop empty data",   64'(data_out), 64'hFFFF);
        check("pop empty accept", 64'(accept),   64'd0);

        // Replace and blank digit.
        step(0, 1, 1, 4'h1);
        check("push+pop empty acts as push", 64'(data_out), 64'hFFF1);
        step(0, 1, 0, 4'h2);
        step(0, 1, 1, 4'h7);
        check("replace data",  64'(data_out), 64'hFF17);
        check("replace count", 64'(count),    64'd2);
        step(0, 1, 0, 4'hF);
        check("blank data",   64'(data_out), 64'hFF17);
        check("blank accept", 64'(accept),   64'd0);

        // Asynchronous reset between edges while a push is pending.
        clr = 1'b0; push = 1'b1; pop = 1'b0; digit = 4'h5;
        #2 rstn = 1'b0;
        #1;
        check("async rst data",  64'(data_out), 64'hFFFF);
        check("async rst count", 64'(count),    64'd0);
        model_reset();
        @(posedge clk); #1;
        check("rst held data", 64'(data_out), 64'hFFFF);
        @(negedge clk);
        rstn = 1'b1;
        push = 1'b0;
        step(0, 1, 0, 4'h3);
        check("after rst push", 64'(data_out), 64'hFFF3);
        step(1, 0, 0, 4'h0);

`ifdef ENTRY_AUTOCLR_EN
        step(0, 1, 0, 4'h9);
        idle(TIMEOUT_CYC - 1);
        check("idle not yet", 64'(count), 64'd1);
        idle(1);
        check("autoclr data",    64'(data_out), 64'hFFFF);
        check("autoclr timeout", 64'(timeout),  64'd1);
        idle(1);
        check("timeout pulse ends", 64'(timeout), 64'd0);
        step(0, 1, 0, 4'h9); step(0, 1, 0, 4'h8);
        idle(4);
        step(0, 0, 1, 4'h0);
        idle(TIMEOUT_CYC - 1);
        check("pop restarted timer", 64'(count), 64'd1);
        idle(1);
        check("autoclr after pop", 64'(timeout), 64'd1);
`else
        step(0, 1, 0, 4'h9);
        idle(TIMEOUT_CYC + 2);
        check("no autoclr", 64'(count), 64'd1);
`endif

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            bit     c, pu, po;
            digit_t d;
            int     r;
            r  = $urandom_range(0, 99);
            c  = (r < 3);
            pu = (r >= 3 && r < 55) || (r >= 80 && r < 88);
            po = (r >= 55 && r < 88);
            d  = digit_t'($urandom_range(0, 14));
            if (pu && !po && digs.size() < DEPTH && $urandom_range(0, 5) == 0) d = BLANK_DIGIT;
            step(c, pu, po, d);
        end

        repeat (2) @(negedge clk);
        check("scoreboard drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
